sprite_mover: RTL and testbench
===============================

Name: sprite_mover

Overview:
- Parametrised successor to the fixed 2x3 player-ship FSM.
- Holds the position of one rectangular sprite of SPR_W x SPR_H pixels and accepts up/down/left/right move requests, with both axes allowed in one move.
- Each accepted move erases the sprite at its old position, then redraws it at the new, clamped position, one pixel per clock, on a VGA-adapter write port.
- Sits between the input/debounce logic and the VGA adapter.

Parameters:
- SPR_W, 2, sprite width in pixels (>=1)
- SPR_H, 3, sprite height in pixels (>=1)
- X_W, 8, width of x coordinates
- Y_W, 7, width of y coordinates
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- STEP, 1, pixels moved per accepted request on each active axis
- INIT_X, 0, x position after reset
- INIT_Y, 60, y position after reset
- SPRITE, {SPR_W*SPR_H{1'b1}}, shape mask; bit (cy*SPR_W+cx) set means foreground pixel
- FG_COLOUR, 3'b111, colour of sprite pixels
- BG_COLOUR, 3'b000, colour used for erase and for mask-0 pixels

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- move_up  in  1  request y decrease
- move_down  in  1  request y increase
- move_left  in  1  request x decrease
- move_right  in  1  request x increase
- vga_x  out  X_W  pixel x to write
- vga_y  out  Y_W  pixel y to write
- colour  out  3  pixel colour
- write_en  out  1  VGA write strobe
- pos_x  out  X_W  current sprite top-left x
- pos_y  out  Y_W  current sprite top-left y
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a draw completes

Behaviour:
- Clock and reset: clock clk. Reset reset_n is synchronous and active-low; it has priority over everything and acts even mid-operation.
- Reset values: state=INIT, pos_x=INIT_X, pos_y=INIT_Y, counters cx=cy=0, write_en=0, busy=1, done=0, vga_x/vga_y/colour=0.
- States:
  - INIT: 1 cycle, then DRAW. The sprite is painted after every reset; nothing is erased.
  - IDLE: samples the request inputs.
  - ERASE: SPR_W*SPR_H cycles.
  - DRAW: SPR_W*SPR_H cycles, then IDLE.
- Scan order: row-major, cx fastest, (0,0) to (SPR_W-1,SPR_H-1). Counters reset to 0 on entry to ERASE and to DRAW.
- Outputs in ERASE/DRAW: write_en=1, vga_x=pos_x+cx, vga_y=pos_y+cy.
  - ERASE: colour=BG_COLOUR.
  - DRAW: colour=FG_COLOUR if SPRITE bit set, else BG_COLOUR.
  - Outputs are combinational from registered state/counters/pos.
- Outputs in INIT/IDLE: write_en=0.
- Move decode in IDLE:
  - dy = -STEP if up&~down; +STEP if down&~up; 0 otherwise.
  - dx likewise for left/right.
- Clamping:
  - Target y = max(0, pos_y-STEP) or min(SCREEN_H-SPR_H, pos_y+STEP); same for x with SCREEN_W-SPR_W.
  - Compute in widened signed arithmetic; no wrap-around.
- Accept: if the clamped target differs from pos, latch the target into nxt_x/nxt_y and go to ERASE. Otherwise stay IDLE with no writes; this covers no request, opposing pair, or being pinned at an edge.
- Position update: pos_x/pos_y <= nxt_x/nxt_y on the ERASE->DRAW edge. pos therefore reflects the old position throughout ERASE.
- Requests are ignored while busy and are not queued; levels are re-sampled on return to IDLE.
- Latency and throughput:
  - Request high in IDLE at edge t: first erase write is the cycle after t.
  - The move occupies 2*SPR_W*SPR_H cycles.
  - done=1 for exactly the first IDLE cycle after DRAW completes, including after the INIT draw.
- A held request repeats a move every 2*SPR_W*SPR_H+1 cycles.

Test Plan:
1. Reset with defaults -> 1 cycle INIT, then 6 writes in FG at (0,60),(1,60),(0,61),(1,61),(0,62),(1,62); then done pulse, busy=0.
2. Pulse move_up for 1 cycle in IDLE -> 6 BG writes at y=60..62, then 6 FG writes at y=59..61; pos_y=59; done once; 13 cycles from accept to done.
3. pos_y=0, move_up held -> no write_en ever, busy stays 0. pos_y=117, move_down -> no writes.
4. move_up&move_down&move_right at (0,60) -> erase, then redraw at (1,60); vertical axis unchanged.
5. move_left asserted during DRAW and dropped before IDLE -> ignored; exactly one redraw occurs.
6. reset_n low in the 3rd ERASE cycle -> next cycle state=INIT, pos=(0,60), write_en=0; full 6-pixel redraw follows.

Source files
------------

// File: rtl/sprite_mover.sv
// Single-sprite position tracker: erases and redraws a SPR_W x SPR_H
// sprite on the VGA write port, one pixel per clock, on each move.
module sprite_mover #(
    parameter int                         SPR_W     = 2,
    parameter int                         SPR_H     = 3,
    parameter int                         X_W       = 8,
    parameter int                         Y_W       = 7,
    parameter int                         SCREEN_W  = 160,
    parameter int                         SCREEN_H  = 120,
    parameter int                         STEP      = 1,
    parameter int                         INIT_X    = 0,
    parameter int                         INIT_Y    = 60,
    parameter logic [SPR_W*SPR_H-1:0]     SPRITE    = '1,
    parameter logic [2:0]                 FG_COLOUR = 3'b111,
    parameter logic [2:0]                 BG_COLOUR = 3'b000
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           move_up,
    input  logic           move_down,
    input  logic           move_left,
    input  logic           move_right,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     colour,
    output logic           write_en,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic           busy,
    output logic           done
);

    localparam int NPIX = SPR_W * SPR_H;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CXW  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int CYW  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int XS   = X_W + 2;
    localparam int YS   = Y_W + 2;

    localparam logic signed [XS-1:0] STEP_X = XS'(STEP);
    localparam logic signed [YS-1:0] STEP_Y = YS'(STEP);
    localparam logic signed [XS-1:0] MAX_X  = XS'(SCREEN_W - SPR_W);
    localparam logic signed [YS-1:0] MAX_Y  = YS'(SCREEN_H - SPR_H);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_ERASE,
        S_DRAW
    } state_t;

    state_t         state_q;
    logic [X_W-1:0] pos_x_q, nxt_x_q;
    logic [Y_W-1:0] pos_y_q, nxt_y_q;
    logic [CXW-1:0] cx_q;
    logic [CYW-1:0] cy_q;
    logic [PW-1:0]  pix_q;
    logic           done_q;

    logic signed [XS-1:0] tx_d;
    logic signed [YS-1:0] ty_d;
    logic [X_W-1:0]       tgt_x;
    logic [Y_W-1:0]       tgt_y;
    logic                 last_pix;
    logic                 scanning;

    // Target position, widened so edges clamp instead of wrapping.
    always_comb begin
        tx_d = signed'({2'b00, pos_x_q});
        if (move_left && !move_right)
            tx_d = tx_d - STEP_X;
        else if (move_right && !move_left)
            tx_d = tx_d + STEP_X;
        if (tx_d[XS-1])
            tx_d = '0;
        else if (tx_d > MAX_X)
            tx_d = MAX_X;

        ty_d = signed'({2'b00, pos_y_q});
        if (move_up && !move_down)
            ty_d = ty_d - STEP_Y;
        else if (move_down && !move_up)
            ty_d = ty_d + STEP_Y;
        if (ty_d[YS-1])
            ty_d = '0;
        else if (ty_d > MAX_Y)
            ty_d = MAX_Y;
    end

    assign tgt_x    = tx_d[X_W-1:0];
    assign tgt_y    = ty_d[Y_W-1:0];
    assign last_pix = (pix_q == PW'(NPIX - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            pos_x_q <= X_W'(INIT_X);
            pos_y_q <= Y_W'(INIT_Y);
            nxt_x_q <= X_W'(INIT_X);
            nxt_y_q <= Y_W'(INIT_Y);
            cx_q    <= '0;
            cy_q    <= '0;
            pix_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_INIT: begin
                    state_q <= S_DRAW;
                    cx_q    <= '0;
                    cy_q    <= '0;
                    pix_q   <= '0;
                end
                S_IDLE: begin
                    if (tgt_x != pos_x_q || tgt_y != pos_y_q) begin
                        nxt_x_q <= tgt_x;
                        nxt_y_q <= tgt_y;
                        state_q <= S_ERASE;
                        cx_q    <= '0;
                        cy_q    <= '0;
                        pix_q   <= '0;
                    end
                end
                S_ERASE, S_DRAW: begin
                    if (last_pix) begin
                        cx_q  <= '0;
                        cy_q  <= '0;
                        pix_q <= '0;
                        if (state_q == S_ERASE) begin
                            state_q <= S_DRAW;
                            pos_x_q <= nxt_x_q;
                            pos_y_q <= nxt_y_q;
                        end else begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        pix_q <= pix_q + 1'b1;
                        if (cx_q == CXW'(SPR_W - 1)) begin
                            cx_q <= '0;
                            cy_q <= cy_q + 1'b1;
                        end else begin
                            cx_q <= cx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign scanning = (state_q == S_ERASE) || (state_q == S_DRAW);
    assign write_en = scanning;
    assign vga_x    = scanning ? pos_x_q + X_W'(cx_q) : '0;
    assign vga_y    = scanning ? pos_y_q + Y_W'(cy_q) : '0;

    always_comb begin
        colour = '0;
        if (state_q == S_ERASE)
            colour = BG_COLOUR;
        else if (state_q == S_DRAW)
            colour = SPRITE[pix_q] ? FG_COLOUR : BG_COLOUR;
    end

    assign pos_x = pos_x_q;
    assign pos_y = pos_y_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover with default parameters.
module tb_sprite_mover;

    logic       clk;
    logic       reset_n;
    logic       move_up, move_down, move_left, move_right;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       write_en;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    sprite_mover dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .move_up    (move_up),
        .move_down  (move_down),
        .move_left  (move_left),
        .move_right (move_right),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .colour     (colour),
        .write_en   (write_en),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Six pixel cycles, row-major, each sampled on the falling edge.
    task automatic scan(input string tag, input int x0, input int y0,
                        input int col);
        for (int cy = 0; cy < 3; cy++) begin
            for (int cx = 0; cx < 2; cx++) begin
                @(negedge clk);
                chk({tag, "_we"}, 32'(write_en), 1);
                chk({tag, "_x"}, 32'(vga_x), x0 + cx);
                chk({tag, "_y"}, 32'(vga_y), y0 + cy);
                chk({tag, "_col"}, 32'(colour), col);
                chk({tag, "_posx"}, 32'(pos_x), x0);
                chk({tag, "_posy"}, 32'(pos_y), y0);
            end
        end
    endtask

    task automatic idle_quiet(input string tag, input int n,
                              input int x0, input int y0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_we"}, 32'(write_en), 0);
            chk({tag, "_busy"}, 32'(busy), 0);
            chk({tag, "_done"}, 32'(done), 0);
            chk({tag, "_posx"}, 32'(pos_x), x0);
            chk({tag, "_posy"}, 32'(pos_y), y0);
        end
    endtask

    task automatic expect_done(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_we"}, 32'(write_en), 0);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_rst_busy"}, 32'(busy), 1);
        chk({tag, "_rst_we"}, 32'(write_en), 0);
        chk({tag, "_rst_done"}, 32'(done), 0);
        chk({tag, "_rst_posx"}, 32'(pos_x), 0);
        chk({tag, "_rst_posy"}, 32'(pos_y), 60);
        chk({tag, "_rst_vx"}, 32'(vga_x), 0);
        chk({tag, "_rst_vy"}, 32'(vga_y), 0);
        chk({tag, "_rst_col"}, 32'(colour), 0);
        reset_n = 1'b1;
        scan({tag, "_init"}, 0, 60, 7);
        expect_done({tag, "_init"});
    endtask

    initial begin
        int cnt;
        reset_n    = 1'b0;
        move_up    = 1'b0;
        move_down  = 1'b0;
        move_left  = 1'b0;
        move_right = 1'b0;

        // Reset and initial paint at (0,60)
        do_reset("t1");

        // Single up pulse: erase at y=60, draw at y=59
        move_up = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t2_e0_we", 32'(write_en), 1);
        chk("t2_e0_y", 32'(vga_y), 60);
        chk("t2_e0_col", 32'(colour), 0);
        move_up = 1'b0;
        for (int cy = 0; cy < 3; cy++) begin
            for (int cx = 0; cx < 2; cx++) begin
                if (cy != 0 || cx != 0) begin
                    @(negedge clk);
                    chk("t2_erase_x", 32'(vga_x), cx);
                    chk("t2_erase_y", 32'(vga_y), 60 + cy);
                    chk("t2_erase_col", 32'(colour), 0);
                    chk("t2_erase_busy", 32'(busy), 1);
                    chk("t2_erase_posy", 32'(pos_y), 60);
                end
            end
        end
        scan("t2_draw", 0, 59, 7);
        expect_done("t2");
        idle_quiet("t2_after", 3, 0, 59);

        // Hold up until pinned at the top edge
        move_up = 1'b1;
        cnt = 0;
        while (!(pos_y == 7'd0 && !busy) && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        chk("t3_up_timeout", 32'(cnt < 3000), 1);
        idle_quiet("t3_top", 20, 0, 0);
        move_up = 1'b0;

        // Hold down until pinned at y=117
        move_down = 1'b1;
        cnt = 0;
        while (!(pos_y == 7'd117 && !busy) && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        chk("t3_dn_timeout", 32'(cnt < 3000), 1);
        idle_quiet("t3_bot", 20, 0, 117);
        move_down = 1'b0;

        // Opposing vertical pair plus right from (0,60)
        do_reset("t4");
        move_up    = 1'b1;
        move_down  = 1'b1;
        move_right = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_e0_we", 32'(write_en), 1);
        chk("t4_e0_x", 32'(vga_x), 0);
        chk("t4_e0_y", 32'(vga_y), 60);
        move_up    = 1'b0;
        move_down  = 1'b0;
        move_right = 1'b0;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            chk("t4_erase_col", 32'(colour), 0);
            chk("t4_erase_we", 32'(write_en), 1);
        end
        scan("t4_draw", 1, 60, 7);
        expect_done("t4");

        // Left request only during DRAW is dropped
        move_down = 1'b1;
        @(posedge clk);
        #1;
        move_down = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_erase_col", 32'(colour), 0);
            chk("t5_erase_posy", 32'(pos_y), 60);
        end
        move_left = 1'b1;
        scan("t5_draw", 1, 61, 7);
        move_left = 1'b0;
        expect_done("t5");
        idle_quiet("t5_quiet", 14, 1, 61);

        // Reset asserted in the third erase cycle
        move_right = 1'b1;
        @(posedge clk);
        #1;
        move_right = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_erase_we", 32'(write_en), 1);
            chk("t6_erase_x", 32'(vga_x), 1 + (i % 2));
            chk("t6_erase_y", 32'(vga_y), 61 + (i / 2));
        end
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_init_busy", 32'(busy), 1);
        chk("t6_init_we", 32'(write_en), 0);
        chk("t6_init_posx", 32'(pos_x), 0);
        chk("t6_init_posy", 32'(pos_y), 60);
        chk("t6_init_done", 32'(done), 0);
        reset_n = 1'b1;
        scan("t6_redraw", 0, 60, 7);
        expect_done("t6");
        idle_quiet("t6_quiet", 3, 0, 60);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
